// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative multiply and shifts behind a start/done handshake.
// Define SEQ_ALU_MUL_EN to build opcode 1000 as the shift-add multiplier; otherwise it returns zero in one cycle.
module seq_alu_core #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             in_it,
  input  logic             start,
  input  logic [3:0]       a_in,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] b_reg,
  input  logic             mux_s,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry,
  output logic             zero,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100, OP_NOT = 4'b0101, OP_INC = 4'b0110, OP_DEC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000, OP_SHL = 4'b1001, OP_SHR = 4'b1010, OP_ROL = 4'b1011;
  localparam logic [3:0] OP_CMP = 4'b1100, OP_SWP = 4'b1101, OP_SEL = 4'b1110, OP_CLR = 4'b1111;

  state_t           r_state, w_next_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_y, r_yhi;
  logic             r_carry, r_zero, r_done, r_busy;

  logic [SHW-1:0]   w_k;
  logic             w_is_shift, w_mul_req, w_multi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sc_y, w_na, w_fin_y, w_fin_hi;
  logic             w_sc_c, w_bit, w_fin_c;

  assign w_k        = b_reg[SHW-1:0];
  assign w_is_shift = (a_in == OP_SHL) || (a_in == OP_SHR) || (a_in == OP_ROL);

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] r_b, r_hi, w_nhi, w_nb;
  logic [WIDTH:0]   w_add;

  assign w_mul_req = (a_in == OP_MUL);
  // r_b holds the unconsumed multiplier bits and fills with product low bits from the top
  assign w_add = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_nhi = w_add[WIDTH:1];
  assign w_nb  = {w_add[0], r_b[WIDTH-1:1]};
`else
  assign w_mul_req = 1'b0;
`endif

  assign w_multi = w_mul_req || (w_is_shift && (w_k != {SHW{1'b0}}));

  // Single-cycle result from the live inputs, used on the accepting edge
  always_comb begin
    w_sum  = {(WIDTH+1){1'b0}};
    w_sc_y = {WIDTH{1'b0}};
    w_sc_c = 1'b0;
    case (a_in)
      OP_ADD: begin
        w_sum  = {1'b0, accum} + {1'b0, b_reg};
        w_sc_y = w_sum[WIDTH-1:0];
        w_sc_c = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sum  = {1'b0, accum} - {1'b0, b_reg};
        w_sc_y = w_sum[WIDTH-1:0];
        w_sc_c = w_sum[WIDTH];
      end
      OP_AND: w_sc_y = accum & b_reg;
      OP_OR:  w_sc_y = accum | b_reg;
      OP_XOR: w_sc_y = accum ^ b_reg;
      OP_NOT: w_sc_y = ~accum;
      OP_INC: begin
        w_sum  = {1'b0, accum} + (WIDTH+1)'(1);
        w_sc_y = w_sum[WIDTH-1:0];
        w_sc_c = w_sum[WIDTH];
      end
      OP_DEC: begin
        w_sum  = {1'b0, accum} - (WIDTH+1)'(1);
        w_sc_y = w_sum[WIDTH-1:0];
        w_sc_c = w_sum[WIDTH];
      end
      OP_SHL, OP_SHR, OP_ROL: w_sc_y = accum;
      OP_CMP: begin
        w_sc_y[2] = (accum < b_reg);
        w_sc_y[1] = (accum == b_reg);
        w_sc_y[0] = (accum > b_reg);
      end
      OP_SWP: w_sc_y = {accum[WIDTH/2-1:0], accum[WIDTH-1:WIDTH/2]};
      OP_SEL: w_sc_y = mux_s ? b_reg : accum;
      OP_MUL, OP_CLR: w_sc_y = {WIDTH{1'b0}};
      default: w_sc_y = {WIDTH{1'b0}};
    endcase
  end

  // One shift/rotate step on the working operand
  always_comb begin
    w_na  = r_a;
    w_bit = 1'b0;
    case (r_op)
      OP_SHL: begin w_na = {r_a[WIDTH-2:0], 1'b0};        w_bit = r_a[WIDTH-1]; end
      OP_SHR: begin w_na = {1'b0, r_a[WIDTH-1:1]};        w_bit = r_a[0];       end
      OP_ROL: begin w_na = {r_a[WIDTH-2:0], r_a[WIDTH-1]}; w_bit = r_a[WIDTH-1]; end
      default: begin w_na = r_a; w_bit = 1'b0; end
    endcase
  end

  // Value loaded into the outputs on the edge that enters DONE
  always_comb begin
    w_fin_y  = w_sc_y;
    w_fin_hi = {WIDTH{1'b0}};
    w_fin_c  = w_sc_c;
    if (r_state == S_EXEC) begin
`ifdef SEQ_ALU_MUL_EN
      if (r_op == OP_MUL) begin
        w_fin_y  = w_nb;
        w_fin_hi = w_nhi;
        w_fin_c  = (w_nhi != {WIDTH{1'b0}});
      end else begin
        w_fin_y = w_na;
        w_fin_c = w_bit;
      end
`else
      w_fin_y = w_na;
      w_fin_c = w_bit;
`endif
    end else begin
      w_fin_y = w_sc_y;
      w_fin_c = w_sc_c;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = w_multi ? S_EXEC : S_DONE;
        else       w_next_state = S_IDLE;
      end
      S_EXEC: begin
        if (r_cnt == (SHW+1)'(1)) w_next_state = S_DONE;
        else                      w_next_state = S_EXEC;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, operand latches, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (in_it) begin
      r_state <= S_IDLE;
      r_op    <= 4'b0000;
      r_a     <= {WIDTH{1'b0}};
      r_cnt   <= {(SHW+1){1'b0}};
      r_y     <= {WIDTH{1'b0}};
      r_yhi   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_b     <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
`endif
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == S_DONE);
      r_busy  <= (w_next_state != S_IDLE);
      if (w_next_state == S_DONE) begin
        r_y     <= w_fin_y;
        r_yhi   <= w_fin_hi;
        r_carry <= w_fin_c;
        r_zero  <= ({w_fin_hi, w_fin_y} == {(2*WIDTH){1'b0}});
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= a_in;
            r_a   <= accum;
            r_cnt <= w_mul_req ? (SHW+1)'(WIDTH) : {1'b0, w_k};
`ifdef SEQ_ALU_MUL_EN
            r_b   <= b_reg;
            r_hi  <= {WIDTH{1'b0}};
`endif
          end
        end
        S_EXEC: begin
          r_a   <= w_na;
          r_cnt <= r_cnt - (SHW+1)'(1);
`ifdef SEQ_ALU_MUL_EN
          if (r_op == OP_MUL) begin
            r_hi <= w_nhi;
            r_b  <= w_nb;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign y_out = r_y;
  assign y_hi  = r_yhi;
  assign carry = r_carry;
  assign zero  = r_zero;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core: directed cases plus random ops against an arithmetic reference model.
module tb_seq_alu_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         in_it, start, mux_s;
  logic [3:0]   a_in;
  logic [W-1:0] accum, b_reg, y_out, y_hi;
  logic         carry, zero, done, busy;
  int           checks = 0;
  int           failures = 0;

  seq_alu_core #(.WIDTH(W)) dut (
    .clk(clk), .in_it(in_it), .start(start), .a_in(a_in), .accum(accum), .b_reg(b_reg),
    .mux_s(mux_s), .y_out(y_out), .y_hi(y_hi), .carry(carry), .zero(zero), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result and completion latency straight from the opcode definitions
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sel, output logic [W-1:0] y, output logic [W-1:0] hi,
                                output logic c, output logic z, output int lat);
    int ai, bi, k, r, m;
    m = (1 << W) - 1;
    ai = int'(a);
    bi = int'(b);
    k = bi % W;
    r = 0; hi = '0; c = 1'b0; lat = 1;
    case (op)
      4'd0:  begin r = ai + bi; c = (r > m); end
      4'd1:  begin r = ai - bi; c = (ai < bi); end
      4'd2:  r = ai & bi;
      4'd3:  r = ai | bi;
      4'd4:  r = ai ^ bi;
      4'd5:  r = ~ai;
      4'd6:  begin r = ai + 1; c = (ai == m); end
      4'd7:  begin r = ai - 1; c = (ai == 0); end
      4'd8:  begin
`ifdef SEQ_ALU_MUL_EN
        r = ai * bi; hi = W'(r >> W); c = ((r >> W) != 0); lat = W + 1;
`else
        r = 0;
`endif
      end
      4'd9:  begin r = ai << k; if (k != 0) begin c = ((ai >> (W - k)) & 1) != 0; lat = k + 1; end end
      4'd10: begin r = ai >> k; if (k != 0) begin c = ((ai >> (k - 1)) & 1) != 0; lat = k + 1; end end
      4'd11: begin
        r = (ai << k) | (ai >> (W - k));
        if (k != 0) begin c = (r & 1) != 0; lat = k + 1; end
      end
      4'd12: r = (ai < bi) ? 4 : ((ai == bi) ? 2 : 1);
      4'd13: r = ((ai & ((1 << (W / 2)) - 1)) << (W / 2)) | (ai >> (W / 2));
      4'd14: r = sel ? bi : ai;
      default: r = 0;
    endcase
    y = W'(r & m);
    z = (y == '0) && (hi == '0);
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sel, input bit poke);
    logic [W-1:0] ey, ehi;
    logic         ec, ez;
    int           elat, lat;
    bit           busy_ok;
    model(op, a, b, sel, ey, ehi, ec, ez, elat);
    a_in = op; accum = a; b_reg = b; mux_s = sel; start = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after acceptance; poke keeps requesting while busy
    start = poke; a_in = 4'($urandom); accum = W'($urandom); b_reg = W'($urandom); mux_s = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin lat = i; break; end
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy"}, 32'(busy_ok), 32'(1));
    chk({tag, " y_out"}, 32'(y_out), 32'(ey));
    chk({tag, " y_hi"}, 32'(y_hi), 32'(ehi));
    chk({tag, " carry"}, 32'(carry), 32'(ec));
    chk({tag, " zero"}, 32'(zero), 32'(ez));
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(done), 32'(0));
    chk({tag, " idle"}, 32'(busy), 32'(0));
    chk({tag, " hold"}, 32'(y_out), 32'(ey));
    start = 1'b0;
  endtask

  task automatic abort_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int seen;
    a_in = op; accum = a; b_reg = b; mux_s = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, " busy before abort"}, 32'(busy), 32'(1));
    in_it = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    in_it = 1'b0;
    chk({tag, " y_out"}, 32'(y_out), 32'(0));
    chk({tag, " y_hi"}, 32'(y_hi), 32'(0));
    chk({tag, " carry"}, 32'(carry), 32'(0));
    chk({tag, " zero"}, 32'(zero), 32'(0));
    chk({tag, " done"}, 32'(done), 32'(0));
    chk({tag, " busy"}, 32'(busy), 32'(0));
    start = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk({tag, " quiet after abort"}, 32'(seen), 32'(0));
  endtask

  initial begin
    in_it = 1'b1; start = 1'b0; a_in = 4'd0; accum = '0; b_reg = '0; mux_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset y_out", 32'(y_out), 32'(0));
    chk("reset y_hi", 32'(y_hi), 32'(0));
    chk("reset carry", 32'(carry), 32'(0));
    chk("reset zero", 32'(zero), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    in_it = 1'b0;

    run_op("add", 4'd0, 8'd200, 8'd100, 1'b0, 1'b0);
    run_op("sub borrow", 4'd1, 8'd5, 8'd25, 1'b0, 1'b0);
    run_op("sub zero", 4'd1, 8'd25, 8'd25, 1'b0, 1'b0);
    run_op("mul max", 4'd8, 8'd255, 8'd255, 1'b0, 1'b1);
    run_op("mul small", 4'd8, 8'd3, 8'd7, 1'b0, 1'b0);
    run_op("shl k3", 4'd9, 8'h81, 8'd3, 1'b0, 1'b1);
    run_op("rol k1", 4'd11, 8'h81, 8'd1, 1'b0, 1'b0);
    run_op("shr k0", 4'd10, 8'h5A, 8'd8, 1'b0, 1'b0);
    run_op("shr k7", 4'd10, 8'hC0, 8'd7, 1'b0, 1'b0);
    run_op("cmp lt", 4'd12, 8'd10, 8'd55, 1'b0, 1'b0);
    run_op("cmp gt", 4'd12, 8'd50, 8'd5, 1'b0, 1'b0);
    run_op("cmp eq", 4'd12, 8'd10, 8'd10, 1'b0, 1'b0);
    run_op("sel a", 4'd14, 8'hA1, 8'h11, 1'b0, 1'b0);
    run_op("sel b", 4'd14, 8'hA1, 8'h11, 1'b1, 1'b1);
    run_op("inc wrap", 4'd6, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("dec wrap", 4'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("swap", 4'd13, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_op("not", 4'd5, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("clear", 4'd15, 8'h77, 8'h88, 1'b0, 1'b0);

    run_op("pre abort", 4'd0, 8'd200, 8'd100, 1'b0, 1'b0);
    abort_op("abort shl", 4'd9, 8'hFF, 8'd7);
`ifdef SEQ_ALU_MUL_EN
    run_op("pre abort mul", 4'd0, 8'd200, 8'd100, 1'b0, 1'b0);
    abort_op("abort mul", 4'd8, 8'd255, 8'd255);
`endif
    run_op("add after abort", 4'd0, 8'd17, 8'd33, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      run_op("rnd", 4'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
